// File: rtl/aes512_dec_scheduler.sv
// Time-shares one AES-128 decryption core across the four 128-bit lanes of a 512-bit block.
// Optional per-lane watchdog is compiled in with `define AES512_SCHED_TIMEOUT_EN.
module aes512_dec_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:511] in_data,
    input  logic [0:511] in_key,
    output logic         core_start,
    output logic [0:127] core_data,
    output logic [0:127] core_key,
    input  logic         core_done,
    input  logic [0:127] core_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:511] out_data,
    output logic         busy,
    output logic [1:0]   lane_idx,
    output logic         err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [1:0]   lane_q, lane_d;
    logic         err_q, err_d;
    logic [0:511] data_q;
    logic [0:511] key_q;
    logic [0:127] lbuf_q [4];
    logic         timeout;

    function automatic logic [0:127] lane_sel(input logic [0:511] v, input logic [1:0] l);
        case (l)
            2'd0:    return v[0:127];
            2'd1:    return v[128:255];
            2'd2:    return v[256:383];
            default: return v[384:511];
        endcase
    endfunction

    // Byte k of lane l lands on output byte 4k+l.
    function automatic logic [0:511] interleave(input logic [0:127] l0, input logic [0:127] l1,
                                                input logic [0:127] l2, input logic [0:127] l3);
        logic [0:511] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[8*(4*k)   +: 8] = l0[8*k +: 8];
            r[8*(4*k+1) +: 8] = l1[8*k +: 8];
            r[8*(4*k+2) +: 8] = l2[8*k +: 8];
            r[8*(4*k+3) +: 8] = l3[8*k +: 8];
        end
        return r;
    endfunction

`ifdef AES512_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is held at zero outside WAIT, so each lane starts a fresh count.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
    end

    assign timeout = (state_q == S_WAIT) && !core_done &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_ISSUE;
                    lane_d  = 2'd0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    if (lane_q == 2'd3) begin
                        state_d = S_OUTPUT;
                    end else begin
                        lane_d  = lane_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
        end
    end

    // Data buffers carry no reset; outputs derived from them are gated by state.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && in_valid) begin
            data_q <= in_data;
            key_q  <= in_key;
        end
        if (state_q == S_WAIT && core_done) lbuf_q[lane_q] <= core_out;
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign core_start = (state_q == S_ISSUE);
    assign out_valid  = (state_q == S_OUTPUT);
    assign lane_idx   = lane_q;
    assign err        = err_q;
    assign core_data  = (state_q == S_ISSUE || state_q == S_WAIT) ? lane_sel(data_q, lane_q) : '0;
    assign core_key   = (state_q == S_ISSUE || state_q == S_WAIT) ? lane_sel(key_q, lane_q) : '0;
    assign out_data   = (state_q == S_OUTPUT) ?
                        interleave(lbuf_q[0], lbuf_q[1], lbuf_q[2], lbuf_q[3]) : '0;

endmodule

// File: tb/tb_aes512_dec_scheduler.sv
// Randomized self-checking bench for aes512_dec_scheduler with a behavioural core model.
module tb_aes512_dec_scheduler;

    localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:511] in_data = '0;
    logic [0:511] in_key = '0;
    logic         core_start;
    logic [0:127] core_data;
    logic [0:127] core_key;
    logic         core_done;
    logic [0:127] core_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:511] out_data;
    logic         busy;
    logic [1:0]   lane_idx;
    logic         err;

    logic         model_done = 1'b0;
    logic [0:127] model_out = '0;
    logic         force_done = 1'b0;
    logic [0:127] force_out = '0;
    logic         mute_lane1 = 1'b0;
    int           core_lat = 10;
    int           core_cnt = 0;
    logic [0:127] pend_d = '0;
    logic [0:127] pend_k = '0;

    int n_tests = 0;
    int n_fail  = 0;

    assign core_done = model_done | force_done;
    assign core_out  = force_done ? force_out : model_out;

    aes512_dec_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .core_start(core_start), .core_data(core_data), .core_key(core_key),
        .core_done(core_done), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .lane_idx(lane_idx), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [0:127] core_fn(input logic [0:127] d, input logic [0:127] k);
        if (d == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
        return d ^ k;
    endfunction

    // Expected block: decrypt each lane, then output byte n is byte n/4 of lane n%4.
    function automatic logic [0:511] ref_out(input logic [0:511] d, input logic [0:511] k);
        logic [0:127] pt [4];
        logic [0:511] r;
        for (int l = 0; l < 4; l++) pt[l] = core_fn(d[128*l +: 128], k[128*l +: 128]);
        for (int n = 0; n < 64; n++) r[8*n +: 8] = pt[n % 4][8*(n/4) +: 8];
        return r;
    endfunction

    // Core model: result pulse exactly core_lat cycles after a start pulse.
    always @(posedge clk) begin
        #1;
        model_done = 1'b0;
        if (rst) begin
            core_cnt = 0;
        end else begin
            if (core_cnt > 0) begin
                core_cnt = core_cnt - 1;
                if (core_cnt == 0) begin
                    model_done = 1'b1;
                    model_out  = core_fn(pend_d, pend_k);
                end
            end
            if (core_start && !(mute_lane1 && lane_idx == 2'd1)) begin
                core_cnt = core_lat;
                pend_d   = core_data;
                pend_k   = core_key;
            end
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_block(input logic [0:511] d, input logic [0:511] k, input int lat,
                             input int hold, input bit spur, input string tag,
                             output logic [0:511] got);
        int n;
        int starts;
        logic [0:511] exp;
        exp = ref_out(d, k);
        core_lat = lat;
        @(negedge clk);
        if (spur) begin
            force_out  = {$urandom, $urandom, $urandom, $urandom};
            force_done = 1'b1;
            @(negedge clk);
            force_done = 1'b0;
        end
        check({tag, ".in_ready"}, 512'(in_ready), 512'(1));
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".err_clr"}, 512'(err), 512'(0));
        n = 1;
        starts = 0;
        while (!out_valid && n < 2000) begin
            force_done = 1'b0;
            if (core_start) begin
                starts++;
                if (spur) begin
                    force_out  = {$urandom, $urandom, $urandom, $urandom};
                    force_done = 1'b1;
                end
            end
            @(negedge clk);
            n++;
        end
        force_done = 1'b0;
        check({tag, ".latency"}, 512'(n), 512'(4*lat + 5));
        check({tag, ".starts"}, 512'(starts), 512'(4));
        check({tag, ".data"}, out_data, exp);
        got = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 512'(out_valid), 512'(1));
            check({tag, ".hold_data"}, out_data, exp);
            check({tag, ".hold_ready"}, 512'(in_ready), 512'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".back_idle"}, 512'(in_ready), 512'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"}, 512'(in_ready), 512'(1));
        check({tag, ".core_start"}, 512'(core_start), 512'(0));
        check({tag, ".out_valid"}, 512'(out_valid), 512'(0));
        check({tag, ".busy"}, 512'(busy), 512'(0));
        check({tag, ".lane_idx"}, 512'(lane_idx), 512'(0));
        check({tag, ".err"}, 512'(err), 512'(0));
        check({tag, ".core_data"}, 512'(core_data), 512'(0));
        check({tag, ".core_key"}, 512'(core_key), 512'(0));
        check({tag, ".out_data"}, out_data, 512'(0));
    endtask

    initial begin
        logic [0:511] d;
        logic [0:511] k;
        logic [0:511] got;
        logic [0:511] exp;
        int n;
        bit seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // FIPS-197 vector in every lane.
        d = {4{FIPS_CT}};
        k = {4{FIPS_KEY}};
        run_block(d, k, 10, 0, 1'b0, "fips", got);
        for (int i = 0; i < 64; i++) exp[8*i +: 8] = 8'((i / 4) * 17);
        check("fips.pattern", got, exp);

        // Distinct lanes: lane l plaintext byte k is 16l+k.
        for (int i = 0; i < 64; i++) k[8*i +: 8] = 8'($urandom);
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < 16; b++) d[128*l + 8*b +: 8] = 8'(16*l + b) ^ k[128*l + 8*b +: 8];
        run_block(d, k, 3, 0, 1'b0, "lanes", got);
        for (int i = 0; i < 64; i++) exp[8*i +: 8] = 8'(16*(i % 4) + i / 4);
        check("lanes.pattern", got, exp);

        // Output back-pressure for 20 cycles.
        for (int i = 0; i < 16; i++) begin
            d[32*i +: 32] = $urandom;
            k[32*i +: 32] = $urandom;
        end
        run_block(d, k, 2, 20, 1'b0, "hold", got);

        // Reset while waiting on lane 2.
        core_lat = 4;
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!(busy && lane_idx == 2'd2 && !core_start) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait.reached", 512'(n < 200), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_wait");
        rst = 1'b0;
        run_block(d, ~k, 1, 1, 1'b0, "after_rst", got);

        // Spurious core_done in IDLE and in ISSUE cycles.
        for (int i = 0; i < 16; i++) begin
            d[32*i +: 32] = $urandom;
            k[32*i +: 32] = $urandom;
        end
        run_block(d, k, 5, 0, 1'b1, "spur", got);

        // Randomized blocks.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) begin
                d[32*i +: 32] = $urandom;
                k[32*i +: 32] = $urandom;
            end
            run_block(d, k, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), "rand", got);
        end

`ifdef AES512_SCHED_TIMEOUT_EN
        // Core never answers lane 1: abort after 16 WAIT cycles.
        mute_lane1 = 1'b1;
        core_lat   = 3;
        in_data    = d;
        in_key     = k;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!(core_start && lane_idx == 2'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo.issue_l1", 512'(n < 200), 512'(1));
        n = 0;
        seen = 1'b0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
        end
        check("tmo.cycles", 512'(n), 512'(17));
        check("tmo.err", 512'(err), 512'(1));
        check("tmo.no_out", 512'(seen), 512'(0));
        mute_lane1 = 1'b0;
        run_block(d, k, 2, 0, 1'b0, "tmo_next", got);
`else
        seen = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule
